// File: rtl/rf_read_sched.sv
// rtl/rf_read_sched.sv - Operand read scheduler sharing one register-file read port between rs1 and rs2.
// Optional feature: define RF_X0_SHORTCUT_EN to resolve x0 operands without a port read.
module rf_read_sched #(
    parameter int RD_LATENCY = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic        rs1_addr_valid,
    input  logic        rs2_addr_valid,
    input  logic        insn_complete,
    output logic        rf_ren,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic [31:0] rs1_rdata,
    output logic [31:0] rs2_rdata,
    output logic        rs1_ready,
    output logic        rs2_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUED = 2'd1,
        ST_READY  = 2'd2
    } src_state_e;

    src_state_e  rs1_st_q, rs1_st_d, rs2_st_q, rs2_st_d;
    logic [31:0] rs1_rdata_q, rs1_rdata_d, rs2_rdata_q, rs2_rdata_d;
    logic        rs1_elig, rs2_elig, rs1_x0, rs2_x0, rs1_gnt, rs2_gnt;
    logic [1:0]  cap;

    always_comb begin
        rs1_elig = resetn && rs1_addr_valid && (rs1_st_q == ST_IDLE) && !insn_complete;
        rs2_elig = resetn && rs2_addr_valid && (rs2_st_q == ST_IDLE) && !insn_complete;
`ifdef RF_X0_SHORTCUT_EN
        rs1_x0 = rs1_elig && (rs1_addr == 5'd0);
        rs2_x0 = rs2_elig && (rs2_addr == 5'd0);
`else
        rs1_x0 = 1'b0;
        rs2_x0 = 1'b0;
`endif
        // An x0 shortcut leaves the port free for the other source.
        rs1_gnt  = rs1_elig && !rs1_x0;
        rs2_gnt  = rs2_elig && !rs2_x0 && !rs1_gnt;
        rf_ren   = rs1_gnt || rs2_gnt;
        rf_raddr = 5'd0;
        if (rs1_gnt) begin
            rf_raddr = rs1_addr;
        end else if (rs2_gnt) begin
            rf_raddr = rs2_addr;
        end
    end

    generate
        if (RD_LATENCY == 0) begin : g_no_pipe
            assign cap  = {rs2_gnt, rs1_gnt};
            assign busy = 1'b0;
        end else begin : g_pipe
            // Stage i holds the {rs2, rs1} tags issued i+1 cycles ago.
            logic [1:0] tag_q [RD_LATENCY];
            logic       busy_acc;

            always_ff @(posedge clk) begin
                if (!resetn || insn_complete) begin
                    for (int i = 0; i < RD_LATENCY; i++) begin
                        tag_q[i] <= 2'b00;
                    end
                end else begin
                    tag_q[0] <= {rs2_gnt, rs1_gnt};
                    for (int i = 1; i < RD_LATENCY; i++) begin
                        tag_q[i] <= tag_q[i-1];
                    end
                end
            end

            always_comb begin
                busy_acc = 1'b0;
                for (int i = 0; i < RD_LATENCY; i++) begin
                    busy_acc = busy_acc | (|tag_q[i]);
                end
            end

            assign busy = busy_acc;
            assign cap  = tag_q[RD_LATENCY-1];
        end
    endgenerate

    always_comb begin
        rs1_st_d    = rs1_st_q;
        rs2_st_d    = rs2_st_q;
        rs1_rdata_d = rs1_rdata_q;
        rs2_rdata_d = rs2_rdata_q;
        if (insn_complete) begin
            rs1_st_d = ST_IDLE;
            rs2_st_d = ST_IDLE;
        end else begin
            if (rs1_gnt) rs1_st_d = ST_ISSUED;
            if (cap[0]) begin
                rs1_st_d    = ST_READY;
                rs1_rdata_d = rf_rdata;
            end
            if (rs1_x0) begin
                rs1_st_d    = ST_READY;
                rs1_rdata_d = 32'd0;
            end
            if (rs2_gnt) rs2_st_d = ST_ISSUED;
            if (cap[1]) begin
                rs2_st_d    = ST_READY;
                rs2_rdata_d = rf_rdata;
            end
            if (rs2_x0) begin
                rs2_st_d    = ST_READY;
                rs2_rdata_d = 32'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rs1_st_q    <= ST_IDLE;
            rs2_st_q    <= ST_IDLE;
            rs1_rdata_q <= 32'd0;
            rs2_rdata_q <= 32'd0;
        end else begin
            rs1_st_q    <= rs1_st_d;
            rs2_st_q    <= rs2_st_d;
            rs1_rdata_q <= rs1_rdata_d;
            rs2_rdata_q <= rs2_rdata_d;
        end
    end

    assign rs1_rdata = rs1_rdata_q;
    assign rs2_rdata = rs2_rdata_q;
    assign rs1_ready = (rs1_st_q == ST_READY);
    assign rs2_ready = (rs2_st_q == ST_READY);

endmodule

// File: tb/tb_rf_read_sched.sv
// tb/tb_rf_read_sched.sv - Self-checking bench for rf_read_sched at RD_LATENCY 3 and 0.
module tb_rf_read_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_addr_valid, rs2_addr_valid, insn_complete;

    logic        ren_3, ren_0, r1_3, r1_0, r2_3, r2_0, busy_3, busy_0;
    logic [4:0]  raddr_3, raddr_0;
    logic [31:0] d1_3, d1_0, d2_3, d2_0;
    logic [31:0] rdata_3, rdata_0;

    logic [31:0] mem [32];
    logic [2:0]  h_ren = 3'b000;
    logic [4:0]  h_addr [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    rf_read_sched #(.RD_LATENCY(3)) dut (
        .clk(clk), .resetn(resetn),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_addr_valid(rs1_addr_valid), .rs2_addr_valid(rs2_addr_valid),
        .insn_complete(insn_complete),
        .rf_ren(ren_3), .rf_raddr(raddr_3), .rf_rdata(rdata_3),
        .rs1_rdata(d1_3), .rs2_rdata(d2_3),
        .rs1_ready(r1_3), .rs2_ready(r2_3), .busy(busy_3)
    );

    rf_read_sched #(.RD_LATENCY(0)) dut0 (
        .clk(clk), .resetn(resetn),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_addr_valid(rs1_addr_valid), .rs2_addr_valid(rs2_addr_valid),
        .insn_complete(insn_complete),
        .rf_ren(ren_0), .rf_raddr(raddr_0), .rf_rdata(rdata_0),
        .rs1_rdata(d1_0), .rs2_rdata(d2_0),
        .rs1_ready(r1_0), .rs2_ready(r2_0), .busy(busy_0)
    );

    // Register-file models: data shows up exactly RD_LATENCY cycles after a read, junk otherwise.
    always @(posedge clk) begin
        h_ren     <= {h_ren[1:0], ren_3};
        h_addr[2] <= h_addr[1];
        h_addr[1] <= h_addr[0];
        h_addr[0] <= raddr_3;
    end
    assign rdata_3 = h_ren[2] ? mem[h_addr[2]] : 32'hBAD0_0003;
    assign rdata_0 = ren_0 ? mem[raddr_0] : 32'hBAD0_0000;

    // Reference model: per DUT k and source s, the cycle of the outstanding read (-1 none).
    int          m_iss  [2][2];
    logic [4:0]  m_addr [2][2];
    bit          m_rdy  [2][2];
    logic [31:0] m_dat  [2][2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 2; s++) begin
                m_iss[k][s]  = -1;
                m_addr[k][s] = 5'd0;
                m_rdy[k][s]  = 1'b0;
                m_dat[k][s]  = 32'd0;
            end
        end
    endtask

    task automatic cycle(input bit rn, input bit v1, input logic [4:0] a1,
                         input bit v2, input logic [4:0] a2, input bit ic);
        @(posedge clk);
        #1;
        resetn = rn; rs1_addr_valid = v1; rs1_addr = a1;
        rs2_addr_valid = v2; rs2_addr = a2; insn_complete = ic;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            int lat;
            bit g0, g1, busy_e;
            logic [4:0] addr_e;
            lat = (k == 0) ? 3 : 0;
            g0 = rn && v1 && (m_iss[k][0] < 0) && !m_rdy[k][0] && !ic;
            g1 = rn && v2 && (m_iss[k][1] < 0) && !m_rdy[k][1] && !ic && !g0;
            addr_e = g0 ? a1 : (g1 ? a2 : 5'd0);
            busy_e = 1'b0;
            for (int s = 0; s < 2; s++) begin
                if (m_iss[k][s] >= 0 && cyc - m_iss[k][s] >= 1 && cyc - m_iss[k][s] <= lat)
                    busy_e = 1'b1;
            end
            chk($sformatf("L%0d rf_ren", lat),    k == 0 ? ren_3   : ren_0,   g0 | g1);
            chk($sformatf("L%0d rf_raddr", lat),  k == 0 ? raddr_3 : raddr_0, addr_e);
            chk($sformatf("L%0d rs1_ready", lat), k == 0 ? r1_3    : r1_0,    m_rdy[k][0]);
            chk($sformatf("L%0d rs2_ready", lat), k == 0 ? r2_3    : r2_0,    m_rdy[k][1]);
            chk($sformatf("L%0d rs1_rdata", lat), k == 0 ? d1_3    : d1_0,    m_dat[k][0]);
            chk($sformatf("L%0d rs2_rdata", lat), k == 0 ? d2_3    : d2_0,    m_dat[k][1]);
            chk($sformatf("L%0d busy", lat),      k == 0 ? busy_3  : busy_0,  busy_e);
            if (!rn) begin
                for (int s = 0; s < 2; s++) begin
                    m_iss[k][s] = -1; m_rdy[k][s] = 1'b0; m_dat[k][s] = 32'd0;
                end
            end else if (ic) begin
                for (int s = 0; s < 2; s++) begin
                    m_iss[k][s] = -1; m_rdy[k][s] = 1'b0;
                end
            end else begin
                if (g0) begin m_iss[k][0] = cyc; m_addr[k][0] = a1; end
                if (g1) begin m_iss[k][1] = cyc; m_addr[k][1] = a2; end
                for (int s = 0; s < 2; s++) begin
                    if (m_iss[k][s] >= 0 && cyc == m_iss[k][s] + lat) begin
                        m_rdy[k][s] = 1'b1;
                        m_dat[k][s] = mem[m_addr[k][s]];
                        m_iss[k][s] = -1;
                    end
                end
            end
        end
        cyc++;
    endtask

    typedef struct {
        bit rn; bit v1; logic [4:0] a1; bit v2; logic [4:0] a2; bit ic;
        bit ren; logic [4:0] raddr; bit r1; bit r2; bit busy;
    } vec_t;

    function automatic vec_t mk(bit rn, bit v1, logic [4:0] a1, bit v2, logic [4:0] a2, bit ic,
                                bit ren, logic [4:0] raddr, bit r1, bit r2, bit busy);
        vec_t v;
        v.rn = rn; v.v1 = v1; v.a1 = a1; v.v2 = v2; v.a2 = a2; v.ic = ic;
        v.ren = ren; v.raddr = raddr; v.r1 = r1; v.r2 = r2; v.busy = busy;
        return v;
    endfunction

    vec_t tbl [19];

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        resetn = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;
        rs1_addr_valid = 1'b0; rs2_addr_valid = 1'b0; insn_complete = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        // Expectations for the RD_LATENCY=3 instance.
        tbl[0]  = mk(0, 1,  9, 1, 10, 0,  0,  0, 0, 0, 0);
        tbl[1]  = mk(1, 1,  3, 1,  4, 0,  1,  3, 0, 0, 0);
        tbl[2]  = mk(1, 1,  3, 1,  4, 0,  1,  4, 0, 0, 1);
        tbl[3]  = mk(1, 1,  3, 1,  4, 0,  0,  0, 0, 0, 1);
        tbl[4]  = mk(1, 1,  3, 1,  4, 0,  0,  0, 0, 0, 1);
        tbl[5]  = mk(1, 1,  3, 1,  4, 0,  0,  0, 1, 0, 1);
        tbl[6]  = mk(1, 1,  3, 1,  4, 0,  0,  0, 1, 1, 0);
        tbl[7]  = mk(1, 1,  3, 1,  4, 1,  0,  0, 1, 1, 0);
        tbl[8]  = mk(1, 0,  0, 0,  0, 0,  0,  0, 0, 0, 0);
        tbl[9]  = mk(1, 1,  5, 0,  0, 0,  1,  5, 0, 0, 0);
        tbl[10] = mk(1, 1,  5, 0,  0, 0,  0,  0, 0, 0, 1);
        tbl[11] = mk(1, 1,  5, 0,  0, 0,  0,  0, 0, 0, 1);
        tbl[12] = mk(1, 1,  5, 0,  0, 0,  0,  0, 0, 0, 1);
        tbl[13] = mk(1, 1,  5, 0,  0, 0,  0,  0, 1, 0, 0);
        tbl[14] = mk(1, 1,  5, 0,  0, 1,  0,  0, 1, 0, 0);
        tbl[15] = mk(1, 1,  0, 1,  7, 0,  1,  0, 0, 0, 0);
        tbl[16] = mk(1, 1,  0, 1,  7, 0,  1,  7, 0, 0, 1);
        tbl[17] = mk(1, 1,  0, 1,  7, 1,  0,  0, 0, 0, 1);
        tbl[18] = mk(1, 0,  0, 0,  0, 0,  0,  0, 0, 0, 0);

        for (int i = 0; i < 19; i++) begin
            cycle(tbl[i].rn, tbl[i].v1, tbl[i].a1, tbl[i].v2, tbl[i].a2, tbl[i].ic);
            chk($sformatf("tbl%0d rf_ren", i),    ren_3,   tbl[i].ren);
            chk($sformatf("tbl%0d rf_raddr", i),  raddr_3, tbl[i].raddr);
            chk($sformatf("tbl%0d rs1_ready", i), r1_3,    tbl[i].r1);
            chk($sformatf("tbl%0d rs2_ready", i), r2_3,    tbl[i].r2);
            chk($sformatf("tbl%0d busy", i),      busy_3,  tbl[i].busy);
        end
        chk("tbl x5 data", d1_3, mem[5]);

        // Release before capture; address changes while issued are ignored.
        cycle(1, 1, 6, 0, 0, 0);  chk("cancel grant", raddr_3, 5'd6);
        cycle(1, 1, 12, 0, 0, 0); chk("no reissue", ren_3, 1'b0);
        cycle(1, 1, 12, 0, 0, 1); chk("no grant on complete", ren_3, 1'b0);
        cycle(1, 1, 8, 0, 0, 0);  chk("regrant addr", raddr_3, 5'd8);
        cycle(1, 0, 0, 0, 0, 0);  chk("cancel not ready", r1_3, 1'b0);
        chk("cancel data held", d1_3, mem[5]);
        cycle(1, 0, 0, 0, 0, 1);

        // Reset mid-flight.
        cycle(1, 1, 20, 0, 0, 0); chk("rst grant", ren_3, 1'b1);
        cycle(0, 1, 21, 1, 22, 0); chk("rst ren gated", ren_3, 1'b0);
        chk("rst raddr gated", raddr_3, 5'd0);
        cycle(0, 1, 21, 1, 22, 0); chk("rst ren gated2", ren_3, 1'b0);
        cycle(1, 0, 0, 0, 0, 0);
        chk("rst ready", r1_3, 1'b0); chk("rst rdata", d1_3, 32'd0); chk("rst busy", busy_3, 1'b0);
        cycle(1, 0, 0, 0, 0, 0);  chk("rst no capture", r1_3, 1'b0);

        // Zero-latency capture.
        cycle(1, 1, 11, 0, 0, 0); chk("L0 grant", raddr_0, 5'd11);
        cycle(1, 0, 0, 0, 0, 0);  chk("L0 ready", r1_0, 1'b1); chk("L0 data", d1_0, mem[11]);
        cycle(1, 0, 0, 0, 0, 1);

        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 63) != 0), $urandom_range(0, 1), 5'($urandom),
                  $urandom_range(0, 1), 5'($urandom), ($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_read_sched.md
RF_READ_SCHED -- requirements
Module: rf_read_sched

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 3, meaning register-file read latency in cycles (legal 0..7).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port resetn  input  1  reset: synchronous, active-low.
REQ-004 SHALL have ports rs1_addr / rs2_addr  input  5  source register indices.
REQ-005 SHALL have ports rs1_addr_valid / rs2_addr_valid  input  1  current instruction needs that operand.
REQ-006 SHALL have port insn_complete  input  1  instruction retires this cycle; releases both operands.
REQ-007 SHALL have port rf_ren  output  1  read issued to shared register-file port this cycle.
REQ-008 SHALL have port rf_raddr  output  5  register-file read address, 0 when rf_ren=0.
REQ-009 SHALL have port rf_rdata  input  32  register-file read data, valid RD_LATENCY cycles after issue.
REQ-010 SHALL have ports rs1_rdata / rs2_rdata  output  32  captured operand values.
REQ-011 SHALL have ports rs1_ready / rs2_ready  output  1  captured operand valid.
REQ-012 SHALL have port busy  output  1  any read in flight.

Function
REQ-013 SHALL keep one FSM per source: IDLE -> ISSUED on grant; ISSUED -> READY on response capture; READY -> IDLE on insn_complete.
REQ-014 SHALL grant the single port to at most one source per cycle, rs1 over rs2; a source is eligible when addr_valid=1, FSM=IDLE and insn_complete=0.
REQ-015 SHALL drive rf_ren=1 and rf_raddr=granted address combinationally in the grant cycle t.
REQ-016 SHALL track in-flight source tags in an RD_LATENCY-deep shift register (one valid bit per source per stage); RD_LATENCY=0 captures in cycle t.
REQ-017 SHALL capture rf_rdata into rsN_rdata at the edge ending cycle t+RD_LATENCY; rsN_ready SHALL be 1 from cycle t+RD_LATENCY+1 until the cycle after insn_complete.
REQ-018 SHALL, on insn_complete, return both FSMs to IDLE and clear all in-flight tags at that edge; responses arriving later SHALL be discarded.
REQ-019 SHALL hold rsN_rdata unchanged outside capture edges (values persist after release).
REQ-020 SHALL issue back-to-back: rs1 at t, rs2 at t+1 when both valid, giving rs2_ready one cycle after rs1_ready.
REQ-021 SHALL not reissue a source in ISSUED or READY; address changes in those states SHALL be ignored until release.
REQ-022 SHALL assert busy when any tag stage is valid.
REQ-023 SHALL, with addr_valid=0, leave that source in IDLE and rsN_ready=0.

Reset
REQ-024 SHALL, while resetn=0 at an edge: FSMs to IDLE, all tags cleared, rs1_rdata=rs2_rdata=0, ready=0, busy=0.
REQ-025 SHALL force rf_ren=0 and rf_raddr=0 combinationally while resetn=0.
REQ-026 SHALL discard any read in flight when reset is applied mid-operation; no capture after reset.

Configuration
REQ-027 SHALL support macro RF_X0_SHORTCUT_EN.
REQ-028 SHALL, with RF_X0_SHORTCUT_EN defined, resolve a valid address 0 without port access: FSM IDLE -> READY in one cycle, rdata=0, no rf_ren; doing so SHALL not consume that cycle's grant, so the other source may issue.
REQ-029 SHALL, without RF_X0_SHORTCUT_EN, treat address 0 like any other index (port read, full latency).

Verification
REQ-030 RD_LATENCY=3, rs1=5 (x5=0x1234), rs2 invalid, grant at t -> rf_ren=1, rf_raddr=5 at t; rs1_ready=1, rs1_rdata=0x1234 at t+4; rs2_ready stays 0.
REQ-031 Both valid rs1=3, rs2=4 at t -> rf_raddr=3 at t, 4 at t+1; rs1_ready at t+4, rs2_ready at t+5; busy=1 during t+1..t+4.
REQ-032 insn_complete at t+2 after rs1 grant at t -> no capture at t+3; rs1_ready=0 at t+4; new grant no earlier than t+3.
REQ-033 resetn=0 at t+1 during in-flight read -> ready=0, rdata=0, busy=0 after reset; no rf_ren while resetn=0.
REQ-034 RF_X0_SHORTCUT_EN defined, rs1=0, rs2=7 at t -> rs1_ready=1 at t+1 with rs1_rdata=0; rf_raddr=7 at t; undefined -> rf_raddr=0 at t, 7 at t+1.
REQ-035 RD_LATENCY=0 single read at t -> ready at t+1 with data sampled in cycle t.
